// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus controller: access sizes,
// controller states and the alignment rule.
package mem_bus_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_RMW_RD,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_DONE
    } state_t;

    // Size 11 has no legal alignment, so it always reports misaligned.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            SZ_WORD: mis = |lo;
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Byte-lane helper: store merge into an old word and
// right-aligning a loaded word to lane 0.
module mem_lane_merge
    import mem_bus_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_lo,
    input  logic [31:0] i_bus,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_merged,
    output logic [31:0] o_shifted
);

    logic [3:0]  w_mask;
    logic [31:0] w_rep;

    // Lane mask and store data replicated across every lane it may hit.
    always_comb begin
        w_mask = 4'b0000;
        w_rep  = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                w_mask = 4'b0001 << i_lo;
                w_rep  = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_mask = 4'b0011 << {i_lo[1], 1'b0};
                w_rep  = {2{i_wdata[15:0]}};
            end
            SZ_WORD: begin
                w_mask = 4'b1111;
                w_rep  = i_wdata;
            end
            default: begin
                w_mask = 4'b0000;
                w_rep  = i_wdata;
            end
        endcase
    end

    // Selected lanes take store data, the rest keep the old word.
    always_comb begin
        o_merged = i_bus;
        for (int k = 0; k < 4; k++) begin
            if (w_mask[k]) begin
                o_merged[8*k +: 8] = w_rep[8*k +: 8];
            end
        end
    end

    // Load data moved down to lane 0, upper bytes zero-filled.
    always_comb begin
        o_shifted = i_bus >> {i_lo, 3'b000};
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Shared word-wide memory bus controller: arbitrates fetch and
// load/store, sequences reads, writes and sub-word read-modify-write.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int DATA_PRIORITY = 1
) (
    input  logic              i_clk,
    input  logic              i_nreset,
    input  logic              i_if_req,
    input  logic [DATA_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_data,
    input  logic              i_ls_req,
    input  logic              i_ls_we,
    input  logic [1:0]        i_ls_size,
    input  logic [DATA_W-1:0] i_ls_addr,
    input  logic [DATA_W-1:0] i_ls_wdata,
    output logic              o_ls_ack,
    output logic [DATA_W-1:0] o_ls_rdata,
    output logic              o_ls_err,
    output logic [DATA_W-1:0] o_memaddr,
    output logic              o_memread,
    inout  wire  [DATA_W-1:0] b_membus
);

    state_t            r_state;
    state_t            w_next;
    logic              r_memread;
    logic [DATA_W-1:0] r_memaddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_owner_ls;
    logic              r_err;
    logic [1:0]        r_size;
    logic [1:0]        r_lo;

    logic              w_pick_ls;
    logic              w_pick_if;
    logic              w_mis;
    logic [DATA_W-1:0] w_addr;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_shifted;

    localparam logic [DATA_W-1:0] LO_MASK = {{(DATA_W-2){1'b0}}, 2'b11};

    // Data port wins ties unless fetch is configured as the favourite.
    assign w_pick_ls = i_ls_req & ((DATA_PRIORITY != 0) | ~i_if_req);
    assign w_pick_if = i_if_req & ~w_pick_ls;
    assign w_mis     = is_misaligned(i_ls_size, i_ls_addr[1:0]);
    assign w_addr    = w_pick_ls ? i_ls_addr : i_if_addr;

    assign o_memaddr  = r_memaddr;
    assign o_memread  = r_memread;
    assign o_if_data  = r_if_data;
    assign o_ls_rdata = r_ls_rdata;
    assign b_membus   = r_memread ? {DATA_W{1'bz}} : r_wdata;

    mem_lane_merge u_lane (
        .i_size    (r_size),
        .i_lo      (r_lo),
        .i_bus     (b_membus),
        .i_wdata   (i_ls_wdata),
        .o_merged  (w_merged),
        .o_shifted (w_shifted)
    );

    // Next state and the one-cycle completion pulses.
    always_comb begin
        w_next   = r_state;
        o_if_ack = 1'b0;
        o_ls_ack = 1'b0;
        o_ls_err = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_ls) begin
                    if (w_mis) begin
                        w_next = ST_DONE;
                    end else if (!i_ls_we) begin
                        w_next = ST_READ;
                    end else if (i_ls_size == SZ_WORD) begin
                        w_next = ST_WR_SETUP;
                    end else begin
                        w_next = ST_RMW_RD;
                    end
                end else if (w_pick_if) begin
                    w_next = ST_READ;
                end
            end
            ST_READ:      w_next = ST_DONE;
            ST_RMW_RD:    w_next = ST_WR_SETUP;
            ST_WR_SETUP:  w_next = ST_WR_STROBE;
            ST_WR_STROBE: w_next = ST_DONE;
            ST_DONE: begin
                w_next   = ST_IDLE;
                o_if_ack = ~r_owner_ls;
                o_ls_ack = r_owner_ls;
                o_ls_err = r_owner_ls & r_err;
            end
            default:      w_next = ST_IDLE;
        endcase
    end

    // State register; memread is registered so the strobe edge is clean.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_state   <= ST_IDLE;
            r_memread <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_memread <= (w_next != ST_WR_STROBE);
        end
    end

    // Request capture, read capture and write data staging.
    always_ff @(posedge i_clk or negedge i_nreset) begin
        if (!i_nreset) begin
            r_memaddr  <= '0;
            r_wdata    <= '0;
            r_if_data  <= '0;
            r_ls_rdata <= '0;
            r_owner_ls <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= SZ_BYTE;
            r_lo       <= 2'b00;
        end else begin
            if (r_state == ST_IDLE && (w_pick_ls || w_pick_if)) begin
                r_owner_ls <= w_pick_ls;
                r_err      <= w_pick_ls & w_mis;
                r_size     <= i_ls_size;
                r_lo       <= i_ls_addr[1:0];
                if (!(w_pick_ls && w_mis)) begin
                    r_memaddr <= w_addr & ~LO_MASK;
                end
                if (w_pick_ls && i_ls_we && !w_mis) begin
                    r_wdata <= i_ls_wdata;
                end
            end
            if (r_state == ST_READ) begin
                if (r_owner_ls) begin
                    r_ls_rdata <= w_shifted;
                end else begin
                    r_if_data <= b_membus;
                end
            end
            if (r_state == ST_RMW_RD) begin
                r_wdata <= w_merged;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (data priority and fetch
// priority), word memories on each bus and a transaction-level model.
module tb_mem_bus_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        if_req   [2];
    logic [31:0] if_addr  [2];
    logic        ls_req   [2];
    logic        ls_we    [2];
    logic [1:0]  ls_size  [2];
    logic [31:0] ls_addr  [2];
    logic [31:0] ls_wdata [2];

    logic        if_ack   [2];
    logic [31:0] if_data  [2];
    logic        ls_ack   [2];
    logic [31:0] ls_rdata [2];
    logic        ls_err   [2];
    logic [31:0] memaddr  [2];
    logic        memread  [2];

    wire  [31:0] bus0;
    wire  [31:0] bus1;

    logic [31:0] mem     [2][256];
    logic [31:0] ref_mem [2][256];
    int          strobes     [2] = '{0, 0};
    int          exp_strobes [2] = '{0, 0};

    int          exp_if_cyc  [2] = '{-1, -1};
    logic [31:0] exp_if_data [2];
    int          exp_ls_cyc  [2] = '{-1, -1};
    logic [31:0] exp_ls_data [2];
    logic        exp_ls_err  [2];
    logic        exp_ls_load [2];
    int          last_if_ack [2] = '{-1, -1};
    int          last_ls_ack [2] = '{-1, -1};

    mem_bus_ctrl #(.DATA_W(32), .DATA_PRIORITY(1)) u_dut0 (
        .i_clk      (clk),
        .i_nreset   (rst_n),
        .i_if_req   (if_req[0]),
        .i_if_addr  (if_addr[0]),
        .o_if_ack   (if_ack[0]),
        .o_if_data  (if_data[0]),
        .i_ls_req   (ls_req[0]),
        .i_ls_we    (ls_we[0]),
        .i_ls_size  (ls_size[0]),
        .i_ls_addr  (ls_addr[0]),
        .i_ls_wdata (ls_wdata[0]),
        .o_ls_ack   (ls_ack[0]),
        .o_ls_rdata (ls_rdata[0]),
        .o_ls_err   (ls_err[0]),
        .o_memaddr  (memaddr[0]),
        .o_memread  (memread[0]),
        .b_membus   (bus0)
    );

    mem_bus_ctrl #(.DATA_W(32), .DATA_PRIORITY(0)) u_dut1 (
        .i_clk      (clk),
        .i_nreset   (rst_n),
        .i_if_req   (if_req[1]),
        .i_if_addr  (if_addr[1]),
        .o_if_ack   (if_ack[1]),
        .o_if_data  (if_data[1]),
        .i_ls_req   (ls_req[1]),
        .i_ls_we    (ls_we[1]),
        .i_ls_size  (ls_size[1]),
        .i_ls_addr  (ls_addr[1]),
        .i_ls_wdata (ls_wdata[1]),
        .o_ls_ack   (ls_ack[1]),
        .o_ls_rdata (ls_rdata[1]),
        .o_ls_err   (ls_err[1]),
        .o_memaddr  (memaddr[1]),
        .o_memread  (memread[1]),
        .b_membus   (bus1)
    );

    assign bus0 = memread[0] ? mem[0][memaddr[0][9:2]] : 32'bz;
    assign bus1 = memread[1] ? mem[1][memaddr[1][9:2]] : 32'bz;

    function automatic logic [31:0] init_word(int i);
        if (i == 16) return 32'h0000_0513;
        if (i == 64) return 32'hDEAD_BEEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, got, exp, cyc);
        end
    endtask

    // Word memories: a write lands on each 1->0 edge of memread.
    initial begin
        logic prev [2];
        for (int d = 0; d < 2; d++) begin
            prev[d] = 1'b1;
            for (int i = 0; i < 256; i++) mem[d][i] = init_word(i);
        end
        forever begin
            @(memread[0] or memread[1]);
            #1;
            for (int d = 0; d < 2; d++) begin
                if (prev[d] && !memread[d]) begin
                    mem[d][memaddr[d][9:2]] = (d == 0) ? bus0 : bus1;
                    strobes[d]++;
                end
                prev[d] = memread[d];
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic e_if;
            logic e_ls;
            if (rst_n !== 1'b1) begin
                chk("rst_if_ack", if_ack[d], 0);
                chk("rst_ls_ack", ls_ack[d], 0);
                chk("rst_ls_err", ls_err[d], 0);
                chk("rst_memread", memread[d], 1);
                chk("rst_memaddr", memaddr[d], 0);
                chk("rst_if_data", if_data[d], 0);
                chk("rst_ls_rdata", ls_rdata[d], 0);
            end else begin
                e_if = (cyc == exp_if_cyc[d]);
                e_ls = (cyc == exp_ls_cyc[d]);
                if (if_ack[d] === 1'b1) last_if_ack[d] = cyc;
                if (ls_ack[d] === 1'b1) last_ls_ack[d] = cyc;
                chk($sformatf("if_ack%0d", d), if_ack[d], e_if);
                chk($sformatf("ls_ack%0d", d), ls_ack[d], e_ls);
                chk($sformatf("ls_err%0d", d), ls_err[d],
                    e_ls & exp_ls_err[d]);
                if (e_if) begin
                    chk($sformatf("if_data%0d", d), if_data[d],
                        exp_if_data[d]);
                end
                if (e_ls && exp_ls_load[d]) begin
                    chk($sformatf("ls_rdata%0d", d), ls_rdata[d],
                        exp_ls_data[d]);
                end
            end
        end
    end

    // Latency from the request-visible cycle to the ack cycle.
    function automatic int ls_lat(logic we, logic [1:0] sz, logic [1:0] lo);
        logic bad;
        bad = (sz == 2'b11) || (sz == 2'b01 && lo[0]) ||
              (sz == 2'b10 && lo != 2'b00);
        if (bad) return 1;
        if (!we) return 2;
        return (sz == 2'b10) ? 3 : 4;
    endfunction

    task automatic model_ls(int d, logic we, logic [1:0] sz,
                            logic [31:0] a, logic [31:0] wd);
        int          nb;
        logic [31:0] w;
        exp_ls_err[d]  = (ls_lat(we, sz, a[1:0]) == 1);
        exp_ls_load[d] = !we && !exp_ls_err[d];
        if (exp_ls_err[d]) return;
        w = ref_mem[d][a[9:2]];
        if (!we) begin
            exp_ls_data[d] = w >> (8 * int'(a[1:0]));
        end else begin
            nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
            for (int k = 0; k < nb; k++) begin
                w[8*(int'(a[1:0])+k) +: 8] = wd[8*k +: 8];
            end
            ref_mem[d][a[9:2]] = w;
            exp_strobes[d]++;
        end
    endtask

    // One access (fetch, load/store or both at once) on instance d.
    task automatic run(int d, logic fe, logic [31:0] fa, logic le,
                       logic we, logic [1:0] sz, logic [31:0] la,
                       logic [31:0] wd);
        int c;
        int ll;
        int tf;
        int tl;
        int last;
        c  = cyc;
        ll = ls_lat(we, sz, la[1:0]);
        if (fe && le) begin
            if (d == 0) begin
                tl = c + ll;
                tf = tl + 1 + 2;
            end else begin
                tf = c + 2;
                tl = tf + 1 + ll;
            end
        end else begin
            tf = c + 2;
            tl = c + ll;
        end
        if (le && (!fe || tl < tf)) begin
            model_ls(d, we, sz, la, wd);
            if (fe) exp_if_data[d] = ref_mem[d][fa[9:2]];
        end else begin
            if (fe) exp_if_data[d] = ref_mem[d][fa[9:2]];
            if (le) model_ls(d, we, sz, la, wd);
        end
        exp_if_cyc[d] = fe ? tf : -1;
        exp_ls_cyc[d] = le ? tl : -1;
        if_req[d]   = fe;
        if_addr[d]  = fa;
        ls_req[d]   = le;
        ls_we[d]    = we;
        ls_size[d]  = sz;
        ls_addr[d]  = la;
        ls_wdata[d] = wd;
        last = (fe && tf > tl) || !le ? tf : tl;
        if (!fe) last = tl;
        repeat (last + 2 - c) begin
            @(posedge clk);
            #1;
            if (fe && cyc == tf + 1) if_req[d] = 1'b0;
            if (le && cyc == tl + 1) ls_req[d] = 1'b0;
        end
        if_req[d] = 1'b0;
        ls_req[d] = 1'b0;
        chk($sformatf("strobes%0d", d), strobes[d], exp_strobes[d]);
    endtask

    initial begin
        int          c0;
        logic [31:0] wd;
        logic [31:0] old;
        for (int d = 0; d < 2; d++) begin
            if_req[d]   = 1'b0;
            if_addr[d]  = '0;
            ls_req[d]   = 1'b0;
            ls_we[d]    = 1'b0;
            ls_size[d]  = 2'b00;
            ls_addr[d]  = '0;
            ls_wdata[d] = '0;
            for (int i = 0; i < 256; i++) ref_mem[d][i] = init_word(i);
        end
        #2 rst_n = 1'b0;
        #21 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fetch of a known instruction word.
        c0 = cyc;
        run(0, 1, 32'h8000_0040, 0, 0, 2'b10, 32'h0, 32'h0);
        chk("fetch_data", if_data[0], 32'h0000_0513);
        chk("fetch_addr", memaddr[0], 32'h8000_0040);
        chk("fetch_lat", last_if_ack[0] - c0, 2);

        // Loads of several sizes and offsets.
        run(0, 0, 0, 1, 0, 2'b01, 32'h8000_0102, 32'h0);
        chk("lh_data", ls_rdata[0], 32'h0000_DEAD);
        run(0, 0, 0, 1, 0, 2'b00, 32'h8000_0101, 32'h0);
        chk("lb_data", ls_rdata[0], 32'h00DE_ADBE);

        // Word store, then a byte merged into it.
        run(0, 0, 0, 1, 1, 2'b10, 32'h8000_0100, 32'h1122_3344);
        chk("sw_mem", mem[0][64], 32'h1122_3344);
        c0 = cyc;
        run(0, 0, 0, 1, 1, 2'b00, 32'h8000_0102, 32'h0000_00AB);
        chk("sb_mem", mem[0][64], 32'h11AB_3344);
        chk("sb_lat", last_ls_ack[0] - c0, 4);
        run(0, 0, 0, 1, 1, 2'b01, 32'h8000_0106, 32'h0000_CAFE);
        chk("sh_mem", mem[0][65], ref_mem[0][65]);
        run(0, 0, 0, 1, 0, 2'b10, 32'h8000_0100, 32'h0);

        // Misaligned and illegal: error, no bus activity.
        old = mem[0][64];
        run(0, 0, 0, 1, 1, 2'b10, 32'h8000_0101, 32'hFFFF_FFFF);
        chk("mis_mem", mem[0][64], old);
        chk("mis_addr", memaddr[0], 32'h8000_0100);
        run(0, 0, 0, 1, 1, 2'b11, 32'h8000_0100, 32'hFFFF_FFFF);
        chk("ill_mem", mem[0][64], old);
        run(0, 0, 0, 1, 0, 2'b01, 32'h8000_0103, 32'h0);

        // Simultaneous requests, both priority settings.
        c0 = cyc;
        run(0, 1, 32'h8000_0040, 1, 0, 2'b10, 32'h8000_0100, 32'h0);
        chk("arb0_ls_lat", last_ls_ack[0] - c0, 2);
        chk("arb0_if_lat", last_if_ack[0] - c0, 5);
        c0 = cyc;
        run(1, 1, 32'h8000_0040, 1, 0, 2'b10, 32'h8000_0100, 32'h0);
        chk("arb1_if_lat", last_if_ack[1] - c0, 2);
        chk("arb1_ls_lat", last_ls_ack[1] - c0, 5);
        chk("arb1_ls_data", ls_rdata[1], 32'hDEAD_BEEF);

        // Store wins and the following fetch sees the new word.
        run(0, 1, 32'h8000_0104, 1, 1, 2'b01, 32'h8000_0104, 32'h0000_BEEF);

        // Reset while the write strobe is low.
        wd = ref_mem[0][66];
        ls_we[0]    = 1'b1;
        ls_size[0]  = 2'b10;
        ls_addr[0]  = 32'h8000_0108;
        ls_wdata[0] = wd;
        ls_req[0]   = 1'b1;
        repeat (2) @(posedge clk);
        exp_strobes[0]++;
        #3;
        rst_n     = 1'b0;
        ls_req[0] = 1'b0;
        #1;
        chk("rst_mid_memread", memread[0], 1);
        chk("rst_mid_memaddr", memaddr[0], 0);
        chk("rst_mid_ack", ls_ack[0], 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_mid_strobes", strobes[0], exp_strobes[0]);
        chk("rst_mid_mem", mem[0][66], init_word(66));
        run(0, 1, 32'h8000_0040, 0, 0, 2'b10, 32'h0, 32'h0);
        chk("post_rst_fetch", if_data[0], 32'h0000_0513);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

endmodule
